// File: rtl/arcade_input_mapper.sv
// PS/2 keymap + joystick merge for arcade cores: keyboard events become held buttons,
// which are ORed with the joystick words, rotated, and given a stretched coin strobe.
module arcade_input_mapper #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned KEY_SLOTS   = 16,
  parameter int unsigned COIN_CYCLES = 1200000,
  localparam int unsigned AddrW      = $clog2(KEY_SLOTS),
  localparam int unsigned MapW       = 14 + $clog2(NUM_PLAYERS)
) (
  input  logic                     clk_sys,
  input  logic                     RESET_N,
  input  logic [64:0]              ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joy_in,
  input  logic [1:0]               orient,
  input  logic                     clear_all,
  input  logic                     map_we,
  input  logic [AddrW-1:0]         map_addr,
  input  logic [MapW-1:0]          map_data,
  output logic [16*NUM_PLAYERS-1:0] joy_out,
  output logic                     coin_out,
  output logic                     start1_out,
  output logic                     start2_out
);

  localparam int unsigned PlW  = $clog2(NUM_PLAYERS);
  localparam int unsigned PlWs = (PlW > 0) ? PlW : 1;
  localparam int unsigned CntW = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(COIN_CYCLES - 1);

  // Keymap entry layout: {valid, key[8:0], player, bit[3:0]}
  function automatic logic [MapW-1:0] default_entry(input int unsigned s);
    logic [8:0] k;
    logic [3:0] b;
    logic       v;
    v = 1'b1;
    k = '0;
    b = '0;
    case (s)
      0:       begin k = 9'h175; b = 4'd3; end
      1:       begin k = 9'h172; b = 4'd2; end
      2:       begin k = 9'h16B; b = 4'd1; end
      3:       begin k = 9'h174; b = 4'd0; end
      4:       begin k = 9'h005; b = 4'd5; end
      5:       begin k = 9'h006; b = 4'd6; end
      6:       begin k = 9'h004; b = 4'd4; end
      default: v = 1'b0;
    endcase
    default_entry             = '0;
    default_entry[MapW-1]     = v;
    default_entry[4+PlW +: 9] = k;
    default_entry[3:0]        = b;
  endfunction

  function automatic logic [PlWs-1:0] slot_player(input logic [MapW-1:0] e);
    slot_player = (PlW == 0) ? '0 : e[4 +: PlWs];
  endfunction

  // Slots 0-3 are the arrow keys and accept either the E0-prefixed or the plain code
  function automatic logic slot_hit(input logic [MapW-1:0] e, input int unsigned s,
                                    input logic ext, input logic [7:0] code);
    logic [8:0] k;
    k = e[4+PlW +: 9];
    slot_hit = e[MapW-1] && (k[7:0] == code) && ((s < 4) || (k[8] == ext));
  endfunction

  function automatic logic [15:0] rotate(input logic [15:0] w, input logic [1:0] o);
    rotate = w;
    case (o)
      2'd0: rotate[3:0] = w[3:0];
      2'd1: rotate[3:0] = {w[1], w[0], w[2], w[3]};
      2'd2: rotate[3:0] = {w[2], w[3], w[0], w[1]};
      2'd3: rotate[3:0] = {w[0], w[1], w[3], w[2]};
      default: rotate[3:0] = w[3:0];
    endcase
  endfunction

  logic [MapW-1:0]                   map_q [KEY_SLOTS];
  logic [NUM_PLAYERS-1:0][15:0]      kb_q, kb_d;
  logic [NUM_PLAYERS-1:0][15:0]      merged;
  logic [16*NUM_PLAYERS-1:0]         joy_d, joy_q;
  logic                              old_toggle_q;
  logic                              evt_fire, evt_pressed, evt_ext;
  logic [7:0]                        evt_code;
  logic [PlWs-1:0]                   hit_pl;
  logic                              coin_c, coin_c_q, coin_q, coin_d;
  logic                              start1_d, start2_d, start1_q, start2_q;
  logic [CntW-1:0]                   cnt_q, cnt_d;

  always_comb begin
    evt_code    = ps2_key[7:0];
    evt_pressed = ps2_key[15:8] != 8'hF0;
    evt_ext     = evt_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    // Multi-byte PRNSCR/PAUSE sequences carry extra bytes and are dropped
    evt_fire    = (old_toggle_q != ps2_key[64]) && (ps2_key[63:24] == '0);
  end

  always_comb begin
    kb_d   = kb_q;
    hit_pl = '0;
    if (clear_all) begin
      kb_d = '0;
    end else if (evt_fire) begin
      for (int unsigned s = 0; s < KEY_SLOTS; s++) begin
        if (slot_hit(map_q[s], s, evt_ext, evt_code)) begin
          hit_pl = slot_player(map_q[s]);
          if (32'(hit_pl) < NUM_PLAYERS) kb_d[hit_pl][map_q[s][3:0]] = evt_pressed;
        end
      end
    end
  end

  always_comb begin
    joy_d    = '0;
    coin_c   = 1'b0;
    start1_d = 1'b0;
    start2_d = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      merged[p]         = joy_in[16*p +: 16] | kb_q[p];
      joy_d[16*p +: 16] = rotate(merged[p], orient);
      coin_c            = coin_c | merged[p][4];
      start1_d          = start1_d | merged[p][5];
      start2_d          = start2_d | merged[p][6];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (coin_c && !coin_c_q) begin
      cnt_d = CntLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    coin_d = coin_c || (cnt_q != '0);
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned s = 0; s < KEY_SLOTS; s++) map_q[s] <= default_entry(s);
    end else if (map_we && (32'(map_addr) < KEY_SLOTS)) begin
      map_q[map_addr] <= map_data;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      // Reload from the live toggle so a stale toggle state is not seen as an event
      old_toggle_q <= ps2_key[64];
      kb_q         <= '0;
      joy_q        <= '0;
      start1_q     <= 1'b0;
      start2_q     <= 1'b0;
      coin_q       <= 1'b0;
      coin_c_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      old_toggle_q <= ps2_key[64];
      kb_q         <= kb_d;
      joy_q        <= joy_d;
      start1_q     <= start1_d;
      start2_q     <= start2_d;
      coin_q       <= coin_d;
      coin_c_q     <= coin_c;
      cnt_q        <= cnt_d;
    end
  end

  assign joy_out    = joy_q;
  assign coin_out   = coin_q;
  assign start1_out = start1_q;
  assign start2_out = start2_q;

endmodule
